// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, default width and command encodings for the SPI slave.
package spi_pkg;
    localparam int DATA_W_DEF = 8;
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
endpackage

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave framing {cmd, payload} to RAM din and serialising RAM dout on MISO.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);
    state_t state, state_n;
    logic rd_addr_done, done, tx_busy, tx_done;
    logic [DATA_W:0] shreg;
    logic [DATA_W-1:0] tx_sh;
    logic [3:0] cnt, tx_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = SS_n ? IDLE :
                  state == IDLE ? CHK_CMD :
                  state == CHK_CMD ? (!MOSI ? WRITE : rd_addr_done ? READ_DATA : READ_ADD) :
                  state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_done <= 1'b0;
            done         <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            cnt          <= '0;
            tx_cnt       <= '0;
            shreg        <= '0;
            tx_sh        <= '0;
            MISO         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n || state == IDLE) begin
                done    <= 1'b0;
                tx_busy <= 1'b0;
                tx_done <= 1'b0;
                cnt     <= '0;
                tx_cnt  <= '0;
                MISO    <= 1'b0;
            end else if (state == CHK_CMD) begin
                shreg <= {shreg[DATA_W-1:0], MOSI};
            end else if (!done) begin
                // shreg holds bits 9..1 when the final bit arrives
                shreg <= {shreg[DATA_W-1:0], MOSI};
                cnt   <= cnt + 4'd1;
                if (cnt == 4'(DATA_W)) begin
                    done         <= 1'b1;
                    rx_valid     <= 1'b1;
                    rx_data      <= {shreg, MOSI};
                    rd_addr_done <= state == READ_ADD ? 1'b1 : state == READ_DATA ? 1'b0 : rd_addr_done;
                end
            end else if (state == READ_DATA) begin
                // one read word per frame; later tx_valid strobes are ignored
                if (tx_busy) begin
                    MISO    <= tx_cnt == 4'(DATA_W) ? 1'b0 : tx_sh[DATA_W-1];
                    tx_sh   <= tx_sh << 1;
                    tx_cnt  <= tx_cnt + 4'd1;
                    tx_busy <= tx_cnt != 4'(DATA_W);
                    tx_done <= tx_cnt == 4'(DATA_W);
                end else if (!tx_done && tx_valid) begin
                    MISO    <= tx_data[DATA_W-1];
                    tx_sh   <= tx_data << 1;
                    tx_cnt  <= 4'd1;
                    tx_busy <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed frames with a scoreboard of expected rx_valid results.
module tb_spi_slave_ctrl;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid;
    logic [9:0] rx_data;
    logic [7:0] tx_data;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        logic [9:0] data;
        state_t     st;
        logic       rd;
    } exp_t;
    exp_t q[$];

    spi_slave_ctrl #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rx_valid) begin
            if (q.size() == 0) begin
                check("spurious_rx_valid", 32'(rx_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("rx_state", 32'(dut.state), 32'(e.st));
                check("rx_rd_addr_done", 32'(dut.rd_addr_done), 32'(e.rd));
            end
        end
    end

    // nbits < 10 aborts the frame by raising SS_n before the next bit is sampled
    task automatic frame(input logic [9:0] f, input int nbits, input bit hold,
                         input bit push, input state_t st, input logic rd);
        if (push) q.push_back('{f, st, rd});
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        for (int i = 9; i > 9 - nbits; i--) begin
            @(negedge clk); MOSI = f[i];
        end
        @(negedge clk);
        if (!hold) begin
            SS_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic read_word(input logic [7:0] d, input int rst_at);
        repeat (2) begin @(negedge clk); MOSI = ~MOSI; end
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0; tx_data = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            check("miso_bit", 32'(MISO), 32'(d[i]));
            if (i == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_miso", 32'(MISO), 32'd0);
                check("rst_state", 32'(dut.state), 32'(IDLE));
                check("rst_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);
                check("rst_rx_data", 32'(rx_data), 32'd0);
                rst_n = 1'b1; SS_n = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk); MOSI = ~MOSI;
        end
        check("miso_idle", 32'(MISO), 32'd0);
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        @(negedge clk);
        check("miso_second_tx_valid", 32'(MISO), 32'd0);
        SS_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        frame({CMD_WR_ADDR, 8'hA5}, 10, 1'b1, 1'b1, WRITE, 1'b0);
        check("write_miso", 32'(MISO), 32'd0);
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0; MOSI = 1'b1;
        check("tx_valid_ignored_1", 32'(MISO), 32'd0);
        @(negedge clk); MOSI = 1'b0;
        check("tx_valid_ignored_2", 32'(MISO), 32'd0);
        SS_n = 1'b1;
        @(negedge clk);
        frame({CMD_WR_DATA, 8'h3C}, 10, 1'b0, 1'b1, WRITE, 1'b0);
        repeat (3) @(negedge clk);
        check("rx_data_hold", 32'(rx_data), 32'h13C);
        frame({CMD_RD_ADDR, 8'h07}, 10, 1'b0, 1'b1, READ_ADD, 1'b1);
        frame({CMD_RD_DATA, 8'h00}, 10, 1'b1, 1'b1, READ_DATA, 1'b0);
        read_word(8'hA5, -1);
        frame({CMD_WR_ADDR, 8'h55}, 5, 1'b0, 1'b0, WRITE, 1'b0);
        check("abort5_state", 32'(dut.state), 32'(IDLE));
        frame({CMD_WR_ADDR, 8'hF0}, 10, 1'b0, 1'b1, WRITE, 1'b0);
        frame({CMD_WR_DATA, 8'h55}, 9, 1'b0, 1'b0, WRITE, 1'b0);
        check("abort_bit0_state", 32'(dut.state), 32'(IDLE));
        check("abort_bit0_rx_data", 32'(rx_data), 32'h0F0);
        frame({CMD_RD_DATA, 8'h81}, 10, 1'b0, 1'b1, READ_ADD, 1'b1);
        frame({CMD_RD_DATA, 8'hFF}, 10, 1'b1, 1'b1, READ_DATA, 1'b0);
        read_word(8'hFF, 4);
        frame({CMD_WR_DATA, 8'h5A}, 10, 1'b0, 1'b1, WRITE, 1'b0);
        repeat (4) @(negedge clk);
        check("rx_queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
